// File: rtl/mem_tile_bist_pkg.sv
// Shared types and the data pattern used by the memory tile BIST manager.
// The pattern function is the single source for both write data and expected read data.
package mem_tile_bist_pkg;

  localparam int unsigned LaneWidth        = 32;
  localparam int unsigned DefaultDataWidth = 512;
  localparam int unsigned DefaultLanes     = DefaultDataWidth / LaneWidth;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WDRAIN,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } bist_state_e;

  // Lane k of word idx: seed + idx*lanes + k, wrapping at 32 bits.
  function automatic logic [31:0] bist_lane(input logic [31:0] seed,
                                            input logic [31:0] idx,
                                            input logic [31:0] k,
                                            input logic [31:0] lanes);
    return seed + idx * lanes + k;
  endfunction

endpackage

// File: rtl/mem_tile_bist_tracker.sv
// Outstanding-request counter plus in-order FIFO of {we, word index} per granted request.
// Responses pop the head, so the checker always knows which word a response belongs to.
module mem_tile_bist_tracker #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push,
  input  logic                push_we,
  input  logic [CntWidth-1:0] push_idx,
  input  logic                rsp_valid,
  output logic                pop,
  output logic                can_issue,
  output logic                head_we,
  output logic [CntWidth-1:0] head_idx,
  output logic                drained
);

  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef struct packed {
    logic                we;
    logic [CntWidth-1:0] idx;
  } entry_t;

  entry_t fifo_mem [MaxOutstanding];

  logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OutWidth-1:0] count_reg, count_next;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign pop       = rsp_valid && (count_reg != '0);
  assign can_issue = count_reg < OutWidth'(MaxOutstanding);
  assign drained   = count_next == '0;
  assign head_we   = fifo_mem[rd_ptr_reg].we;
  assign head_idx  = fifo_mem[rd_ptr_reg].idx;

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push && !pop) begin
      count_next = count_reg + OutWidth'(1);
    end else if (!push && pop) begin
      count_next = count_reg - OutWidth'(1);
    end
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_reg + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_reg + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{we: push_we, idx: push_idx};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(rsp_valid && count_reg == '0));
    end
  end

endmodule

// File: rtl/mem_tile_obi_bist.sv
// OBI manager that writes a deterministic pattern over an address range, reads it back
// and compares, reporting pass/fail, the mismatch count and the first failing address.
module mem_tile_obi_bist
  import mem_tile_bist_pkg::*;
#(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [CntWidth-1:0]    num_words_i,
  input  logic [31:0]            seed_i,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   we_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [IdWidth-1:0]     aid_o,
  input  logic                   rvalid_i,
  input  logic [DataWidth-1:0]   rdata_i,
  input  logic                   err_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [CntWidth-1:0]    err_cnt_o,
  output logic [AddrWidth-1:0]   fail_addr_o
);

  localparam int unsigned Lanes     = DataWidth / LaneWidth;
  localparam int unsigned WordBytes = DataWidth / 8;

  bist_state_e          state_reg, state_next;
  logic [AddrWidth-1:0] base_reg, base_next;
  logic [CntWidth-1:0]  num_reg, num_next;
  logic [CntWidth-1:0]  idx_reg, idx_next;
  logic [31:0]          seed_reg, seed_next;
  logic [CntWidth-1:0]  err_cnt_reg, err_cnt_next;
  logic [AddrWidth-1:0] fail_addr_reg, fail_addr_next;
  logic                 abort_reg, abort_next;
  logic                 done_reg, done_next;
  logic                 pass_reg, pass_next;

  logic                 fire;
  logic                 last_word;
  logic                 can_issue;
  logic                 rsp_pop;
  logic                 head_we;
  logic [CntWidth-1:0]  head_idx;
  logic                 drained;
  logic                 rsp_fail;
  logic [AddrWidth-1:0] head_addr;
  logic [DataWidth-1:0] wr_pattern;
  logic [DataWidth-1:0] exp_pattern;

  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_lane
      assign wr_pattern[gi*LaneWidth +: LaneWidth] =
        bist_lane(seed_reg, 32'(idx_reg), 32'(gi), 32'(Lanes));
      assign exp_pattern[gi*LaneWidth +: LaneWidth] =
        bist_lane(seed_reg, 32'(head_idx), 32'(gi), 32'(Lanes));
    end
  endgenerate

  // req_o is a pure function of registered state, so it drops with the async reset
  // and cannot fall while waiting for a grant (the outstanding count only decreases then).
  assign req_o     = ((state_reg == ST_WRITE) || (state_reg == ST_READ)) && can_issue;
  assign fire      = req_o && gnt_i;
  assign last_word = idx_reg == (num_reg - CntWidth'(1));
  assign we_o      = state_reg == ST_WRITE;
  assign addr_o    = base_reg + AddrWidth'(idx_reg) * AddrWidth'(WordBytes);
  assign wdata_o   = we_o ? wr_pattern : '0;
  assign aid_o     = '0;
  assign busy_o    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  // Full-word strobes for the whole run; zero at reset and while idle.
  assign be_o      = busy_o ? '1 : '0;

  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign err_cnt_o   = err_cnt_reg;
  assign fail_addr_o = fail_addr_reg;

  mem_tile_bist_tracker #(
    .MaxOutstanding (MaxOutstanding),
    .CntWidth       (CntWidth)
  ) i_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (fire),
    .push_we   (we_o),
    .push_idx  (idx_reg),
    .rsp_valid (rvalid_i),
    .pop       (rsp_pop),
    .can_issue (can_issue),
    .head_we   (head_we),
    .head_idx  (head_idx),
    .drained   (drained)
  );

  assign head_addr = base_reg + AddrWidth'(head_idx) * AddrWidth'(WordBytes);
  assign rsp_fail  = rsp_pop && (err_i || (!head_we && (rdata_i != exp_pattern)));

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    num_next       = num_reg;
    seed_next      = seed_reg;
    idx_next       = fire ? idx_reg + CntWidth'(1) : idx_reg;
    abort_next     = abort_reg;
    done_next      = done_reg;
    pass_next      = pass_reg;
    err_cnt_next   = err_cnt_reg;
    fail_addr_next = fail_addr_reg;

    if (rsp_fail) begin
      if (err_cnt_reg != {CntWidth{1'b1}}) begin
        err_cnt_next = err_cnt_reg + CntWidth'(1);
      end
      // err_cnt saturates and never returns to zero, so zero marks "no failure yet".
      if (err_cnt_reg == '0) begin
        fail_addr_next = head_addr;
      end
    end

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          base_next      = base_addr_i;
          num_next       = num_words_i;
          seed_next      = seed_i;
          idx_next       = '0;
          err_cnt_next   = '0;
          fail_addr_next = '0;
          abort_next     = 1'b0;
          done_next      = 1'b0;
          pass_next      = 1'b0;
          if (num_words_i == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            pass_next  = 1'b1;
          end else begin
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (abort_i) begin
          state_next = ST_RDRAIN;
          abort_next = 1'b1;
        end else if (fire && last_word) begin
          state_next = ST_WDRAIN;
          idx_next   = '0;
        end
      end
      ST_WDRAIN: begin
        if (abort_i) begin
          state_next = ST_RDRAIN;
          abort_next = 1'b1;
        end else if (drained) begin
          state_next = ST_READ;
          idx_next   = '0;
        end
      end
      ST_READ: begin
        if (abort_i) begin
          state_next = ST_RDRAIN;
          abort_next = 1'b1;
        end else if (fire && last_word) begin
          state_next = ST_RDRAIN;
        end
      end
      ST_RDRAIN: begin
        // Leave as the final response lands so its check is folded into pass.
        if (drained) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          pass_next  = (err_cnt_next == '0) && !abort_reg;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      num_reg       <= '0;
      seed_reg      <= '0;
      idx_reg       <= '0;
      err_cnt_reg   <= '0;
      fail_addr_reg <= '0;
      abort_reg     <= 1'b0;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      num_reg       <= num_next;
      seed_reg      <= seed_next;
      idx_reg       <= idx_next;
      err_cnt_reg   <= err_cnt_next;
      fail_addr_reg <= fail_addr_next;
      abort_reg     <= abort_next;
      done_reg      <= done_next;
      pass_reg      <= pass_next;
    end
  end

endmodule

// File: tb/tb_mem_tile_obi_bist.sv
// Scoreboard bench: expected requests and run results are queued at start and
// compared as the DUT issues handshakes and reaches Done.
`timescale 1ns/1ps
module tb_mem_tile_obi_bist;

  localparam int AW    = 48;
  localparam int DW    = 512;
  localparam int IW    = 4;
  localparam int MO    = 2;
  localparam int CW    = 16;
  localparam int LANES = DW / 32;
  localparam int WB    = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_words_i;
  logic [31:0]   seed_i;
  logic          req_o;
  logic          gnt_i;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic [WB-1:0] be_o;
  logic [DW-1:0] wdata_o;
  logic [IW-1:0] aid_o;
  logic          rvalid_i;
  logic [DW-1:0] rdata_i;
  logic          err_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] fail_addr_o;

  always #5 clk_i = ~clk_i;

  mem_tile_obi_bist #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .IdWidth        (IW),
    .MaxOutstanding (MO),
    .CntWidth       (CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .seed_i      (seed_i),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .wdata_o     (wdata_o),
    .aid_o       (aid_o),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i),
    .err_i       (err_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .err_cnt_o   (err_cnt_o),
    .fail_addr_o (fail_addr_o)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int due; logic we; logic [AW-1:0] addr; } rsp_t;
  typedef struct { logic pass; logic [CW-1:0] err_cnt; logic [AW-1:0] fail_addr; } res_t;

  req_t          exp_q[$];
  rsp_t          rsp_q[$];
  res_t          res_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            lat, gnt_pct, abort_at, rst_at, abort_cyc, out_cnt;
  int            n_wr_gnt, n_rd_gnt, run_cycles;
  logic          flip_en;
  logic [AW-1:0] flip_addr;
  logic          pend_prev, abort_pend, rst_pend, req_seen;
  logic [31:0]   w1_lane0;

  task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input logic [31:0] seed, input int idx);
    logic [DW-1:0] w;
    for (int k = 0; k < LANES; k++) begin
      w[k*32 +: 32] = seed + 32'(idx) * 32'(LANES) + 32'(k);
    end
    return w;
  endfunction

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step();
    rsp_t          r;
    req_t          e;
    logic [DW-1:0] d;
    int            out_before;
    out_before = out_cnt;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    err_i    = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      rvalid_i = 1'b1;
      out_cnt--;
      if (!r.we) begin
        d = mem.exists(r.addr) ? mem[r.addr] : '0;
        if (flip_en && r.addr == flip_addr) d[3] = ~d[3];
        rdata_i = d;
      end
    end
    gnt_i = ($urandom_range(99) < 32'(gnt_pct));
    #1;
    if (req_o) req_seen = 1'b1;
    if (pend_prev && !abort_i) check_value("req_held", DW'(req_o), DW'(1));
    if (abort_i && cyc > abort_cyc) check_value("req_after_abort", DW'(req_o), '0);
    if (req_o && exp_q.size() == 0) begin
      check_value("req_unexpected", DW'(req_o), '0);
    end else if (req_o) begin
      e = exp_q[0];
      check_value("req_we", DW'(we_o), DW'(e.we));
      check_value("req_addr", DW'(addr_o), DW'(e.addr));
      check_value("req_wdata", wdata_o, e.data);
      if (gnt_i) begin
        void'(exp_q.pop_front());
        check_value("req_be", DW'(be_o), DW'({WB{1'b1}}));
        check_value("outstanding_lt_max", DW'(out_before < MO), DW'(1));
        if (we_o) begin
          mem[addr_o] = wdata_o;
          if (n_wr_gnt == 1) w1_lane0 = wdata_o[31:0];
          n_wr_gnt++;
          if (abort_at != 0 && n_wr_gnt == abort_at) abort_pend = 1'b1;
        end else begin
          n_rd_gnt++;
          if (rst_at != 0 && n_rd_gnt == rst_at) rst_pend = 1'b1;
        end
        rsp_q.push_back('{due: cyc + lat, we: we_o, addr: addr_o});
        out_cnt++;
      end
    end
    pend_prev = req_o && !gnt_i;
    @(negedge clk_i);
    cyc++;
    rvalid_i = 1'b0;
    gnt_i    = 1'b0;
    if (abort_pend) begin
      abort_i    = 1'b1;
      abort_cyc  = cyc;
      abort_pend = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_req"}, DW'(req_o), '0);
    check_value({tag, "_busy"}, DW'(busy_o), '0);
    check_value({tag, "_done"}, DW'(done_o), '0);
    check_value({tag, "_pass"}, DW'(pass_o), '0);
    check_value({tag, "_err_cnt"}, DW'(err_cnt_o), '0);
    check_value({tag, "_fail_addr"}, DW'(fail_addr_o), '0);
    check_value({tag, "_addr"}, DW'(addr_o), '0);
    check_value({tag, "_we_be"}, DW'({we_o, be_o}), '0);
    check_value({tag, "_wdata"}, wdata_o, '0);
  endtask

  task automatic run_bist(input logic [AW-1:0] base, input int num, input logic [31:0] seed,
                          input int l, input int gp, input int flip_word, input int ab_at,
                          input int r_at, input logic exp_pass, input int exp_err,
                          input logic [AW-1:0] exp_fail);
    res_t res;
    int   steps;
    lat = l; gnt_pct = gp; abort_at = ab_at; rst_at = r_at;
    n_wr_gnt = 0; n_rd_gnt = 0; abort_cyc = 32'h7fff_ffff;
    req_seen = 1'b0; pend_prev = 1'b0; abort_pend = 1'b0; rst_pend = 1'b0;
    flip_en   = (flip_word >= 0);
    flip_addr = base + AW'(flip_word) * AW'(WB);
    for (int i = 0; i < num; i++) exp_q.push_back('{1'b1, base + AW'(i) * AW'(WB), pattern(seed, i)});
    for (int i = 0; i < num; i++) exp_q.push_back('{1'b0, base + AW'(i) * AW'(WB), '0});
    res_q.push_back('{exp_pass, CW'(exp_err), exp_fail});
    base_addr_i = base;
    num_words_i = CW'(num);
    seed_i      = seed;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    steps   = 1;
    while (!done_o && !rst_pend && steps < 2000) begin
      step();
      steps++;
    end
    run_cycles = steps;
    if (rst_pend) begin
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      rsp_q.delete();
      exp_q.delete();
      void'(res_q.pop_front());
      out_cnt  = 0;
      rst_pend = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      $display("run base=%h num=%0d seed=%h reset during read after %0d read grants", base, num, seed, n_rd_gnt);
      return;
    end
    check_value("done", DW'(done_o), DW'(1));
    check_value("busy_at_done", DW'(busy_o), '0);
    res = res_q.pop_front();
    check_value("pass", DW'(pass_o), DW'(res.pass));
    check_value("err_cnt", DW'(err_cnt_o), DW'(res.err_cnt));
    check_value("fail_addr", DW'(fail_addr_o), DW'(res.fail_addr));
    if (ab_at == 0) check_value("all_requests_issued", DW'(exp_q.size()), '0);
    exp_q.delete();
    rsp_q.delete();
    out_cnt = 0;
    abort_i = 1'b0;
    $display("run base=%h num=%0d seed=%h cycles=%0d pass=%0b err_cnt=%0d fail_addr=%h",
             base, num, seed, run_cycles, pass_o, err_cnt_o, fail_addr_o);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    seed_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    out_cnt = 0; w1_lane0 = '0; flip_en = 1'b0; flip_addr = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Clean run, full-rate grants, 1-cycle memory.
    run_bist(48'h7000_0000, 8, 32'hA5A5_0000, 1, 100, -1, 0, 0, 1'b1, 0, '0);
    check_value("latency_le_20", DW'(run_cycles <= 20), DW'(1));
    check_value("w1_lane0", DW'(w1_lane0), DW'(32'hA5A5_0010));

    // Bit 3 of word 5 corrupted on read.
    run_bist(48'h7000_0000, 8, 32'hA5A5_0000, 1, 100, 5, 0, 0, 1'b0, 1, 48'h7000_0140);

    // Random grants, 3-cycle memory.
    run_bist(48'h0012_3400_0000, 20, 32'hDEAD_BEEF, 3, 50, -1, 0, 0, 1'b1, 0, '0);

    // Zero-length run.
    run_bist(48'h7000_0000, 0, 32'h1, 1, 100, -1, 0, 0, 1'b1, 0, '0);
    check_value("num0_latency", DW'(run_cycles), DW'(1));
    check_value("num0_no_req", DW'(req_seen), '0);

    // Abort after the third write grant.
    run_bist(48'h7000_0000, 8, 32'h0BAD_0000, 1, 100, -1, 3, 0, 1'b0, 0, '0);

    // Reset in the read phase, then a clean rerun.
    run_bist(48'h0000_5000, 10, 32'h1357_9BDF, 2, 70, -1, 0, 4, 1'b1, 0, '0);
    run_bist(48'h0000_5000, 10, 32'h1357_9BDF, 2, 70, -1, 0, 0, 1'b1, 0, '0);

    // Address range wrapping past the top of the address space, with a failure after the wrap.
    run_bist(48'hFFFF_FFFF_FFC0, 3, 32'hFFFF_FFF8, 1, 80, 2, 0, 0, 1'b0, 1, 48'h0000_0000_0040);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
